branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch resolution unit for the ID stage. It compares two register operands under a 4-bit branch opcode and computes the resolved next PC (taken: `pc+offset+2`, not-taken: `pc+4`). It checks the result against a prediction and, on a mispredict, issues a one-cycle redirect followed by a counted flush window. It generalises the 16-bit branch comparator to any width, adds signed and not-equal conditions, a stall input, and an optional 2-bit saturating predictor table.

## Interface
- `WIDTH`, 16: datapath and PC width.
- `PHT_DEPTH`, 16: predictor entries; power of two, ≥2.
- `FLUSH_CYCLES`, 2: hazard window length after a mispredict, 1..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid` in 1: a candidate branch instruction is present this cycle.
- `stall` in 1: pipeline stall; freezes all state.
- `opCode` in 4: branch opcode.
- `RD1` in WIDTH: first operand.
- `R0R` in WIDTH: second operand.
- `pc` in WIDTH: PC of the branch.
- `offset` in WIDTH: branch offset.
- `branch` out WIDTH: registered resolved next PC of the last accepted branch.
- `redirect` out 1: registered one-cycle pulse; fetch must load `branch`.
- `hazard` out 1: registered; high while younger instructions are being squashed.
- `pred_taken` out 1: combinational prediction for the current `pc`.

## Operation
- Opcodes:
  - 0100 BLT, unsigned `<`.
  - 0101 BGT, unsigned `>`.
  - 0110 BEQ.
  - 0111 BNE.
  - 1000 BLTS, signed `<`.
  - 1001 BGTS, signed `>`.
  - All other opcodes are non-branch: no state change.
- Accept condition: `valid && !stall && is_branch && !hazard`. Valid inputs during `hazard` are squashed and ignored.
- Target arithmetic: taken → `pc+offset+2`; not-taken → `pc+4`. Both are WIDTH bits, modulo 2^WIDTH. The offset is added as raw bits.
- On accept:
  - `branch` ← resolved target.
  - mispredict = (taken != predicted).
  - On mispredict: `redirect` ← 1 and flush counter ← FLUSH_CYCLES.
  - Otherwise: `redirect` ← 0.
- `redirect` clears on every edge that does not accept a mispredicted branch, including stalled edges.
- Flush counter: `hazard` = (counter != 0). The counter decrements by 1 per non-stalled edge and holds while `stall` is high.
- Predictor index: `pc[log2(PHT_DEPTH):1]`. Each entry is a 2-bit counter; predict taken when bit[1]=1.
- Predictor update on accept: taken → saturating increment to 11; not-taken → saturating decrement to 00.
- Reset values: `branch`=0, `redirect`=0, `hazard`=0, counter=0, all predictor entries=01.

## Timing
- Prediction has zero latency: `pred_taken` is combinational from `pc`.
- Resolution latency is one cycle: `branch` and `redirect` are valid after the accept edge.
- `hazard` rises on the same edge as `redirect` and stays high for exactly FLUSH_CYCLES non-stalled cycles.
- Stall during flush extends `hazard` by the number of stalled cycles.
- Simultaneous `valid` and `stall`: no accept, no predictor update.
- Reset asserted mid-flush: `hazard`, `redirect` and the counter clear immediately (asynchronous), and the predictor reinitialises.
- Back-to-back accepted branches: each resolves independently. A predictor read-after-write to the same index sees the updated value on the next cycle.

## Configuration
- `BRANCH_PREDICT_EN` defined: the predictor table is present and behaves as described above.
- `BRANCH_PREDICT_EN` undefined:
  - No table is built.
  - `pred_taken` is constant 0 (static not-taken).
  - Every taken branch is a mispredict and every not-taken branch is correct.

## Test plan
All scenarios use WIDTH=16, PHT_DEPTH=16, FLUSH_CYCLES=2 and `BRANCH_PREDICT_EN` defined unless noted.
1. Reset, then BEQ with `RD1`=`R0R`=0x0005, `pc`=0x0010, `offset`=0x0020 → `pred_taken`=0; next cycle `branch`=0x0032, `redirect`=1 for 1 cycle, `hazard`=1 for 2 cycles; entry 8 becomes 10.
2. Repeat scenario 1 after the flush ends → `pred_taken`=1, `redirect` stays 0, `branch`=0x0032; entry 8 becomes 11.
3. Signed vs unsigned compare with `RD1`=0xFFFF, `R0R`=0x0001, `pc`=0x0040:
   - BLTS with `offset`=0x0008 → `branch`=0x004A.
   - BLT → not-taken, `branch`=0x0044, `redirect`=0.
4. Wrap-around: BEQ taken with `pc`=0xFFFE, `offset`=0x0004 → `branch`=0x0004. BNE not-taken with `pc`=0xFFFE → `branch`=0x0002.
5. Flush behaviour:
   - A valid BEQ during `hazard` is ignored: `branch` and the predictor are unchanged.
   - `stall`=1 for 3 cycles inside the window → `hazard` lasts 5 cycles total.
6. Reset and macro-off cases:
   - Deassert `rst_n` while `hazard`=1 → `hazard` and `redirect` drop immediately; after release, scenario 1 repeats identically.
   - With `BRANCH_PREDICT_EN` undefined, scenario 2 → `redirect`=1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// ID-stage branch resolution. The unit compares RD1 and R0R under a 4-bit
// branch opcode and computes the resolved next PC. A taken branch goes to
// pc+offset+2 and a not-taken branch goes to pc+4. It then checks the
// outcome against the prediction. A mispredict raises a one-cycle redirect
// and opens a flush window that lasts FLUSH_CYCLES non-stalled cycles.
//
// Optional feature macro: BRANCH_PREDICT_EN
//   defined   - a PHT_DEPTH-entry table of 2-bit saturating counters,
//               indexed by pc[log2(PHT_DEPTH):1], supplies the prediction.
//   undefined - no table is built; the prediction is static not-taken.
//
// Parameters:
//   WIDTH        datapath and PC width
//   PHT_DEPTH    predictor entries (power of two, >= 2)
//   FLUSH_CYCLES flush window length after a mispredict (1..15)
//
// Ports:
//   clk        in          rising-edge clock
//   rst_n      in          asynchronous active-low reset
//   valid      in          candidate branch present this cycle
//   stall      in          pipeline stall; freezes all state
//   opCode     in  [3:0]   branch opcode
//   RD1        in  [W-1:0] first operand
//   R0R        in  [W-1:0] second operand
//   pc         in  [W-1:0] PC of the branch
//   offset     in  [W-1:0] branch offset (added as raw bits)
//   branch     out [W-1:0] registered resolved next PC of last accepted branch
//   redirect   out         registered one-cycle pulse on mispredict
//   hazard     out         high while younger instructions are squashed
//   pred_taken out         combinational prediction for the current pc
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int WIDTH        = 16,
  parameter int PHT_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             stall,
  input  logic [3:0]       opCode,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] R0R,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] branch,
  output logic             redirect,
  output logic             hazard,
  output logic             pred_taken
);

  localparam int         IDX_W      = $clog2(PHT_DEPTH);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  localparam logic [3:0] OP_BLT  = 4'b0100;
  localparam logic [3:0] OP_BGT  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_BLTS = 4'b1000;
  localparam logic [3:0] OP_BGTS = 4'b1001;

  logic             is_branch;
  logic             taken;
  logic             predicted;
  logic             accept;
  logic             mispredict;
  logic [WIDTH-1:0] target;
  logic [3:0]       flush_cnt;

  // Condition evaluation; any opcode outside the branch set is a non-branch.
  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    case (opCode)
      OP_BLT:  taken = (RD1 < R0R);
      OP_BGT:  taken = (RD1 > R0R);
      OP_BEQ:  taken = (RD1 == R0R);
      OP_BNE:  taken = (RD1 != R0R);
      OP_BLTS: taken = ($signed(RD1) < $signed(R0R));
      OP_BGTS: taken = ($signed(RD1) > $signed(R0R));
      default: is_branch = 1'b0;
    endcase
  end

  // Both targets wrap modulo 2^WIDTH.
  assign target = taken ? (pc + offset + WIDTH'(2)) : (pc + WIDTH'(4));

  // The flush counter is the only hazard state; hazard is a pure decode of it.
  assign hazard     = (flush_cnt != 4'd0);
  assign accept     = valid && !stall && is_branch && !hazard;
  assign mispredict = (taken != predicted);
  assign pred_taken = predicted;

  // Resolved PC, redirect pulse and flush window. Redirect is recomputed on
  // every edge, so it drops even on stalled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch    <= '0;
      redirect  <= 1'b0;
      flush_cnt <= 4'd0;
    end else begin
      redirect <= accept && mispredict;
      if (accept) begin
        branch <= target;
      end
      if (accept && mispredict) begin
        flush_cnt <= FLUSH_INIT;
      end else if (!stall && hazard) begin
        flush_cnt <= flush_cnt - 4'd1;
      end
    end
  end

`ifdef BRANCH_PREDICT_EN
  logic [IDX_W-1:0] pht_idx;
  logic [1:0]       pht [PHT_DEPTH];

  // Bit 0 is ignored because branches sit on 2-byte boundaries.
  assign pht_idx   = pc[IDX_W:1];
  assign predicted = pht[pht_idx][1];

  // Saturating 2-bit counters, all starting weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (accept) begin
      if (taken && (pht[pht_idx] != 2'b11)) begin
        pht[pht_idx] <= pht[pht_idx] + 2'd1;
      end else if (!taken && (pht[pht_idx] != 2'b00)) begin
        pht[pht_idx] <= pht[pht_idx] - 2'd1;
      end
    end
  end
`else
  // Static not-taken: every taken branch is a mispredict.
  assign predicted = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Scoreboard bench for branch_resolve_unit (WIDTH=16, PHT_DEPTH=16,
// FLUSH_CYCLES=2). Every cycle, applyStimulus drives the inputs. It checks
// pred_taken against a reference model, advances the model by one edge and
// pushes the expected registered outputs to a queue. A monitor pops one
// entry per rising edge and compares it. Spot checks with fixed values
// cover the named scenarios. Follows BRANCH_PREDICT_EN like the design.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int FLUSH = 2;
`ifdef BRANCH_PREDICT_EN
  localparam logic PRED_EN = 1'b1;
`else
  localparam logic PRED_EN = 1'b0;
`endif

  localparam logic [3:0] BLT  = 4'b0100;
  localparam logic [3:0] BNE  = 4'b0111;
  localparam logic [3:0] BEQ  = 4'b0110;
  localparam logic [3:0] BLTS = 4'b1000;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        stall;
  logic [3:0]  opCode;
  logic [15:0] RD1;
  logic [15:0] R0R;
  logic [15:0] pc;
  logic [15:0] offset;
  logic [15:0] branch;
  logic        redirect;
  logic        hazard;
  logic        pred_taken;

  branch_resolve_unit #(
    .WIDTH(16),
    .PHT_DEPTH(16),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid(valid),
    .stall(stall),
    .opCode(opCode),
    .RD1(RD1),
    .R0R(R0R),
    .pc(pc),
    .offset(offset),
    .branch(branch),
    .redirect(redirect),
    .hazard(hazard),
    .pred_taken(pred_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [15:0] branch;
    logic        redirect;
    logic        hazard;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  logic [1:0]  m_pht [16];
  int          m_cnt;
  logic [15:0] m_branch;
  logic        m_redirect;
  logic        hz_seen;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic modelPred(input logic [15:0] p);
    if (PRED_EN) return m_pht[p[4:1]][1];
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_pht[i] = 2'b01;
    m_cnt      = 0;
    m_branch   = 16'h0000;
    m_redirect = 1'b0;
  endtask

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic applyStimulus(input logic v, input logic st, input logic [3:0] op,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] p, input logic [15:0] off);
    logic is_br;
    logic tk;
    logic pr;
    logic acc;
    exp_t e;
    @(posedge clk);
    #2;
    hz_seen = hazard;
    valid   = v;
    stall   = st;
    opCode  = op;
    RD1     = a;
    R0R     = b;
    pc      = p;
    offset  = off;
    #1;
    pr = modelPred(p);
    checkOutput($sformatf("pred_taken@%0d", cyc), {31'b0, pred_taken}, {31'b0, pr});
    is_br = 1'b1;
    tk    = 1'b0;
    case (op)
      4'h4: tk = (a < b);
      4'h5: tk = (a > b);
      4'h6: tk = (a == b);
      4'h7: tk = (a != b);
      4'h8: tk = ($signed(a) < $signed(b));
      4'h9: tk = ($signed(a) > $signed(b));
      default: is_br = 1'b0;
    endcase
    acc = v && !st && is_br && (m_cnt == 0);
    if (acc) begin
      m_branch   = tk ? (p + off + 16'd2) : (p + 16'd4);
      m_redirect = (tk != pr);
      if (tk != pr) m_cnt = FLUSH;
      if (PRED_EN) begin
        if (tk && m_pht[p[4:1]] != 2'b11) m_pht[p[4:1]] = m_pht[p[4:1]] + 2'd1;
        if (!tk && m_pht[p[4:1]] != 2'b00) m_pht[p[4:1]] = m_pht[p[4:1]] - 2'd1;
      end
    end else begin
      m_redirect = 1'b0;
      if (!st && m_cnt > 0) m_cnt--;
    end
    e.id       = cyc;
    e.branch   = m_branch;
    e.redirect = m_redirect;
    e.hazard   = (m_cnt != 0);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  // Asserts reset mid-cycle, holds it for two edges, then releases it.
  task automatic doReset();
    rst_n  = 1'b0;
    valid  = 1'b0;
    stall  = 1'b0;
    opCode = 4'h0;
    exp_q.delete();
    modelReset();
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: one expected entry per edge, checked just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput($sformatf("branch@%0d", e.id), {16'b0, branch}, {16'b0, e.branch});
      checkOutput($sformatf("redirect@%0d", e.id), {31'b0, redirect}, {31'b0, e.redirect});
      checkOutput($sformatf("hazard@%0d", e.id), {31'b0, hazard}, {31'b0, e.hazard});
    end
  end

  initial begin
    int hz;
    rst_n   = 1'b0;
    valid   = 1'b0;
    stall   = 1'b0;
    opCode  = 4'h0;
    RD1     = 16'h0;
    R0R     = 16'h0;
    pc      = 16'h0;
    offset  = 16'h0;
    hz_seen = 1'b0;
    modelReset();
    #3;
    checkOutput("rst_branch", {16'b0, branch}, 32'h0);
    checkOutput("rst_redirect", {31'b0, redirect}, 32'h0);
    checkOutput("rst_hazard", {31'b0, hazard}, 32'h0);
    checkOutput("rst_pred", {31'b0, pred_taken}, 32'h0);
    #14;
    rst_n = 1'b1;

    $display("[TB] scenario 1: first BEQ mispredicts");
    applyStimulus(1'b1, 1'b0, BEQ, 16'h0005, 16'h0005, 16'h0010, 16'h0020);
    idle(1);
    checkOutput("s1_branch", {16'b0, branch}, 32'h0032);
    checkOutput("s1_redirect", {31'b0, redirect}, 32'h1);
    idle(3);

    $display("[TB] scenario 2: repeated BEQ");
    applyStimulus(1'b1, 1'b0, BEQ, 16'h0005, 16'h0005, 16'h0010, 16'h0020);
    idle(1);
    checkOutput("s2_branch", {16'b0, branch}, 32'h0032);
    checkOutput("s2_redirect", {31'b0, redirect}, {31'b0, !PRED_EN});
    idle(3);

    $display("[TB] scenario 3: unsigned vs signed compare");
    doReset();
    applyStimulus(1'b1, 1'b0, BLT, 16'hFFFF, 16'h0001, 16'h0040, 16'h0008);
    idle(1);
    checkOutput("s3_blt_branch", {16'b0, branch}, 32'h0044);
    checkOutput("s3_blt_redirect", {31'b0, redirect}, 32'h0);
    applyStimulus(1'b1, 1'b0, BLTS, 16'hFFFF, 16'h0001, 16'h0040, 16'h0008);
    idle(1);
    checkOutput("s3_blts_branch", {16'b0, branch}, 32'h004A);
    idle(3);

    $display("[TB] scenario 4: wrap-around");
    applyStimulus(1'b1, 1'b0, BEQ, 16'h0003, 16'h0003, 16'hFFFE, 16'h0004);
    idle(1);
    checkOutput("s4_beq_branch", {16'b0, branch}, 32'h0004);
    idle(3);
    applyStimulus(1'b1, 1'b0, BNE, 16'h0003, 16'h0003, 16'hFFFE, 16'h0004);
    idle(1);
    checkOutput("s4_bne_branch", {16'b0, branch}, 32'h0002);
    idle(3);
    // Non-branch opcode and valid-with-stall must not be accepted.
    applyStimulus(1'b1, 1'b0, 4'h0, 16'h0001, 16'h0001, 16'h0100, 16'h0010);
    applyStimulus(1'b1, 1'b1, BEQ, 16'h0001, 16'h0001, 16'h0100, 16'h0010);
    idle(1);
    checkOutput("s4_nochange", {16'b0, branch}, 32'h0002);

    $display("[TB] scenario 5: flush squash and stall extension");
    applyStimulus(1'b1, 1'b0, BNE, 16'h0001, 16'h0002, 16'h0100, 16'h0010);
    hz = 0;
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(i == 1, (i >= 2) && (i <= 4), BEQ, 16'h0003, 16'h0003,
                    16'h0200, 16'h0040);
      if (hz_seen) hz++;
    end
    checkOutput("s5_hazard_len", hz, 32'd5);
    checkOutput("s5_squashed", {16'b0, branch}, 32'h0112);
    idle(2);

    $display("[TB] scenario 6: reset during flush");
    applyStimulus(1'b1, 1'b0, BNE, 16'h0001, 16'h0002, 16'h0006, 16'h0010);
    @(posedge clk);
    #4;
    checkOutput("s6_pre_hazard", {31'b0, hazard}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_hazard", {31'b0, hazard}, 32'h0);
    checkOutput("s6_rst_redirect", {31'b0, redirect}, 32'h0);
    doReset();
    applyStimulus(1'b1, 1'b0, BEQ, 16'h0005, 16'h0005, 16'h0010, 16'h0020);
    idle(1);
    checkOutput("s6_branch", {16'b0, branch}, 32'h0032);
    checkOutput("s6_redirect", {31'b0, redirect}, 32'h1);
    idle(3);

    @(posedge clk);
    #2;
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
